seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the same 16-opcode map and the CF/ZF/SF flags, and adds three things: a WIDTH parameter, a valid/ready interface with registered results, and iterative multi-cycle multiply and divide with full-width high/remainder output. It sits between the operand-issue logic and the result writeback, and accepts back-to-back single-cycle ops at one per clock.

## Interface
- WIDTH, 8: operand and result width. Must be a power of two, 4..64.
- CLK  in  1  clock. All logic is on the rising edge.
- RST  in  1  synchronous reset, active-high.
- IN_VALID  in  1  operand/opcode valid.
- IN_READY  out  1  block can accept. Transfer occurs when IN_VALID && IN_READY.
- A, B  in  WIDTH  unsigned operands.
- SELC  in  4  opcode.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts. Transfer occurs when OUT_VALID && OUT_READY.
- ALU_OUT  out  WIDTH  result, low half.
- ALU_OUT_HI  out  WIDTH  MUL high half or DIV remainder. 0 for all other ops.
- CF, ZF, SF, DZ  out  1  carry, zero, sign, and divide-by-zero flags.

## Operation
- Opcodes (unsigned; S = B mod WIDTH):
  - 0 ADD: CF = carry-out.
  - 1 SUB: A−B; CF = borrow (A<B).
  - 2 MUL: {HI,OUT} = A*B; CF = (HI≠0).
  - 3 DIV: OUT = quotient, HI = remainder.
  - 4 SHL by S: CF = last bit shifted out (0 if S=0).
  - 5 SHR by S, logical: CF as for SHL.
  - 6 ROL by S, 7 ROR by S.
  - 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR.
  - E GT: OUT = (A>B).
  - F EQ: OUT = (A==B).
- CF = 0 for every op not listed with a CF rule above.
- ZF = (ALU_OUT == 0) and SF = ALU_OUT[WIDTH−1], both from the low half only. DZ = 0 except for DIV with B=0.
- DIV with B=0: OUT = all ones, HI = A, DZ = 1, CF = 0. Completes in the single-cycle path; no iteration.
- FSM states:
  - IDLE: on accept, a single-cycle op (or DIV with B=0) goes to DONE; MUL or DIV (B≠0) goes to BUSY.
  - BUSY: counter runs WIDTH iterations. MUL uses shift-add; DIV uses restoring division. Goes to DONE after the last iteration.
  - DONE: holds outputs with OUT_VALID=1. On OUT_READY: a new accept in the same cycle follows IDLE's rules; otherwise go to IDLE.
- IN_READY = !RST && (state==IDLE || (state==DONE && OUT_READY)). Combinational.
- Operands and opcode are captured on accept. Later input changes have no effect until the next accept.
- Result and flag outputs are registered, and stable while OUT_VALID && !OUT_READY.

## Timing
- Reset values: state = IDLE; OUT_VALID, ALU_OUT, ALU_OUT_HI, CF, ZF, SF, DZ all 0; iteration counter 0. IN_READY is 0 while RST is high.
- Single-cycle op: accepted at edge k, OUT_VALID high from edge k+1. Throughput is 1/clock when OUT_READY is held high.
- MUL/DIV: accepted at edge k, BUSY for WIDTH cycles, OUT_VALID high from edge k+WIDTH+1. IN_READY is 0 throughout BUSY.
- Simultaneous output drain and input accept in DONE is legal. No bubble is inserted for single-cycle ops.
- RST asserted in any state, including mid-BUSY, aborts the op. No OUT_VALID is produced for it. IN_READY returns 1 in the first cycle after RST deasserts.
- The iteration counter is $clog2(WIDTH+1) bits and must never wrap.

## Structure
- Shared package alu_defs holds:
  - opcode constants OP_ADD..OP_EQ, with values 4'h0..4'hF as listed above;
  - FSM state encoding ST_IDLE, ST_BUSY, ST_DONE.
  The existing combinational ALU migrates to the same constants.
- One sub-module, seq_alu_muldiv:
  - iterative multiply/divide unit with its own counter;
  - start/done pulse interface;
  - parameter WIDTH.
- The top level holds the FSM, the single-cycle datapath, flag generation and the output registers.

## Test plan
All cases use WIDTH=8.
- ADD A=F0 B=20 -> OUT=10, CF=1, ZF=0, SF=0; OUT_VALID one cycle after accept.
- MUL A=4C B=1F -> OUT=34, HI=09, CF=1; OUT_VALID 9 cycles after accept; IN_READY low for 8 BUSY cycles.
- DIV A=90 B=08 -> OUT=12, HI=00, DZ=0, latency 9. DIV A=55 B=00 -> OUT=FF, HI=55, DZ=1, latency 1.
- SHL A=85 B=09 -> OUT=0A, CF=1. ROR A=F0 B=04 -> OUT=0F, CF=0. EQ A=F0 B=F0 -> OUT=01. GT A=F0 B=F0 -> OUT=00, ZF=1.
- Stream 4 ADDs with OUT_READY high -> 4 results on consecutive cycles. Drop OUT_READY for 3 cycles -> outputs and flags hold, IN_READY=0.
- RST at cycle 4 of a MUL -> all outputs 0, OUT_VALID never asserts for that op, IN_READY=1 the cycle after RST drops.

Source files
------------

// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared opcode map and FSM state encoding for the ALU family
//
// Purpose: one place for the 16-entry opcode map used by both the legacy
// combinational ALU and seq_alu, plus the seq_alu controller state encoding.
// Ports: none (package).
package alu_defs;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide by zero is resolved immediately, so only MUL and DIV with a
  // non-zero divisor need the iterative unit.
  function automatic logic is_iterative(input logic [3:0] op, input logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand/result handshake bundle for seq_alu
//
// Purpose: groups the issue-side and writeback-side handshakes of seq_alu.
// Signals: IN_VALID/IN_READY, A, B, SELC (issue side);
//          OUT_VALID/OUT_READY, ALU_OUT, ALU_OUT_HI, CF, ZF, SF, DZ (result side).
// Modports: master = operand issuer / result consumer, slave = the ALU.
interface seq_alu_if #(parameter int WIDTH = 8);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       SELC;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] ALU_OUT;
  logic [WIDTH-1:0] ALU_OUT_HI;
  logic             CF;
  logic             ZF;
  logic             SF;
  logic             DZ;

  modport master (
    output IN_VALID, A, B, SELC, OUT_READY,
    input  IN_READY, OUT_VALID, ALU_OUT, ALU_OUT_HI, CF, ZF, SF, DZ
  );

  modport slave (
    input  IN_VALID, A, B, SELC, OUT_READY,
    output IN_READY, OUT_VALID, ALU_OUT, ALU_OUT_HI, CF, ZF, SF, DZ
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// rtl/seq_alu_muldiv.sv - iterative shift-add multiplier / restoring divider
//
// Purpose: WIDTH-iteration unsigned multiply and divide sharing one pair of
// working registers.
// Ports: clk, rst (sync active-high); start loads a, b, is_div;
//        done pulses in the cycle of the final iteration, with lo/hi
//        presenting the value that iteration produces (product low/high or
//        quotient/remainder), so the caller can register it on that edge.
module seq_alu_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  import alu_defs::*;

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic             div_q;
  logic [WIDTH-1:0] r_hi;   // MUL: partial product high; DIV: remainder
  logic [WIDTH-1:0] r_lo;   // MUL: multiplier/product low; DIV: dividend/quotient
  logic [WIDTH-1:0] opnd;   // MUL: multiplicand; DIV: divisor
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] n_hi;
  logic [WIDTH-1:0] n_lo;

  always_comb begin
    add_sum = {1'b0, r_hi} + {1'b0, opnd};
    shifted = {r_hi, r_lo[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};
    n_hi    = r_hi;
    n_lo    = r_lo;
    if (div_q) begin
      // Restoring step: keep the subtraction only if it did not go negative.
      if (!trial[WIDTH]) begin
        n_hi = trial[WIDTH-1:0];
        n_lo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        n_hi = shifted[WIDTH-1:0];
        n_lo = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add step: the carry of the add becomes the new top bit.
      if (r_lo[0]) begin
        {n_hi, n_lo} = {add_sum, r_lo[WIDTH-1:1]};
      end else begin
        {n_hi, n_lo} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
      opnd  <= '0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      div_q <= is_div;
      r_hi  <= '0;
      r_lo  <= a;
      opnd  <= b;
    end else if (cnt != '0) begin
      cnt   <= cnt - CW'(1);
      r_hi  <= n_hi;
      r_lo  <= n_lo;
    end
  end

  assign done = (cnt == CW'(1));
  assign lo   = n_lo;
  assign hi   = n_hi;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with registered results and iterative MUL/DIV
//
// Purpose: accepts one op per clock, computes single-cycle ops directly and
// hands MUL / DIV (non-zero divisor) to seq_alu_muldiv; results and flags are
// registered and held until the consumer takes them.
// Ports: CLK, RST (sync active-high); bus (seq_alu_if.slave) carrying the
//        issue handshake with A, B, SELC and the result handshake with
//        ALU_OUT, ALU_OUT_HI, CF, ZF, SF, DZ.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  seq_alu_if.slave bus
);
  import alu_defs::*;

  localparam int SW = $clog2(WIDTH);

  state_t           state;
  state_t           state_n;
  logic             accept;
  logic             b_zero;
  logic             iter_op;
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic             md_is_div;
  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   wide;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_cf;
  logic             sc_dz;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] hi_q;
  logic             cf_q;
  logic             zf_q;
  logic             sf_q;
  logic             dz_q;

  assign bus.IN_READY = !RST && ((state == ST_IDLE) || ((state == ST_DONE) && bus.OUT_READY));
  assign accept  = bus.IN_VALID && bus.IN_READY;
  assign b_zero  = (bus.B == '0);
  assign iter_op = is_iterative(bus.SELC, b_zero);
  assign shamt   = bus.B[SW-1:0];

  // Single-cycle datapath, evaluated on the live operands and captured on accept.
  always_comb begin
    sc_lo = '0;
    sc_hi = '0;
    sc_cf = 1'b0;
    sc_dz = 1'b0;
    wide  = '0;
    dbl   = '0;
    case (bus.SELC)
      OP_ADD: begin
        wide  = {1'b0, bus.A} + {1'b0, bus.B};
        sc_lo = wide[WIDTH-1:0];
        sc_cf = wide[WIDTH];
      end
      OP_SUB: begin
        wide  = {1'b0, bus.A} - {1'b0, bus.B};
        sc_lo = wide[WIDTH-1:0];
        sc_cf = wide[WIDTH];
      end
      OP_DIV: begin
        if (b_zero) begin
          sc_lo = '1;
          sc_hi = bus.A;
          sc_dz = 1'b1;
        end
      end
      // The extra bit on each side catches the last bit shifted out.
      OP_SHL: begin
        wide  = {1'b0, bus.A} << shamt;
        sc_lo = wide[WIDTH-1:0];
        sc_cf = wide[WIDTH];
      end
      OP_SHR: begin
        wide  = {bus.A, 1'b0} >> shamt;
        sc_lo = wide[WIDTH:1];
        sc_cf = wide[0];
      end
      OP_ROL: begin
        dbl   = {bus.A, bus.A} << shamt;
        sc_lo = dbl[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        dbl   = {bus.A, bus.A} >> shamt;
        sc_lo = dbl[WIDTH-1:0];
      end
      OP_AND:  sc_lo = bus.A & bus.B;
      OP_OR:   sc_lo = bus.A | bus.B;
      OP_XOR:  sc_lo = bus.A ^ bus.B;
      OP_NOR:  sc_lo = ~(bus.A | bus.B);
      OP_NAND: sc_lo = ~(bus.A & bus.B);
      OP_XNOR: sc_lo = ~(bus.A ^ bus.B);
      OP_GT:   sc_lo = {{(WIDTH-1){1'b0}}, (bus.A > bus.B)};
      OP_EQ:   sc_lo = {{(WIDTH-1){1'b0}}, (bus.A == bus.B)};
      default: ;
    endcase
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (CLK),
    .rst    (RST),
    .start  (accept && iter_op),
    .is_div (bus.SELC == OP_DIV),
    .a      (bus.A),
    .b      (bus.B),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_n = iter_op ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (md_done) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (bus.OUT_READY) begin
          if (accept) state_n = iter_op ? ST_BUSY : ST_DONE;
          else        state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // accept and md_done are mutually exclusive: accept needs IDLE/DONE, done needs BUSY.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q     <= '0;
      hi_q      <= '0;
      cf_q      <= 1'b0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      dz_q      <= 1'b0;
      md_is_div <= 1'b0;
    end else if (accept && !iter_op) begin
      out_q <= sc_lo;
      hi_q  <= sc_hi;
      cf_q  <= sc_cf;
      zf_q  <= (sc_lo == '0);
      sf_q  <= sc_lo[WIDTH-1];
      dz_q  <= sc_dz;
    end else if (accept) begin
      md_is_div <= (bus.SELC == OP_DIV);
    end else if (md_done) begin
      out_q <= md_lo;
      hi_q  <= md_hi;
      cf_q  <= !md_is_div && (md_hi != '0);
      zf_q  <= (md_lo == '0);
      sf_q  <= md_lo[WIDTH-1];
      dz_q  <= 1'b0;
    end
  end

  assign bus.OUT_VALID  = (state == ST_DONE);
  assign bus.ALU_OUT    = out_q;
  assign bus.ALU_OUT_HI = hi_q;
  assign bus.CF         = cf_q;
  assign bus.ZF         = zf_q;
  assign bus.SF         = sf_q;
  assign bus.DZ         = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu against an arithmetic model
module tb_seq_alu;
  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int MASK = MOD - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic cf, zf, sf, dz;
    int   lat;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } pend_t;

  pend_t q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit rst_applied = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    int ai, bi, s, t, th;
    ai = int'(a); bi = int'(b); s = bi % W; t = 0; th = 0;
    r.cf = 1'b0; r.dz = 1'b0; r.lat = 1;
    case (op)
      4'h0: begin t = ai + bi; r.cf = (t >= MOD); end
      4'h1: begin t = ai - bi + MOD; r.cf = (ai < bi); end
      4'h2: begin t = ai * bi; th = t / MOD; r.cf = (th != 0); r.lat = W + 1; end
      4'h3: begin
        if (bi == 0) begin t = MASK; th = ai; r.dz = 1'b1; end
        else begin t = ai / bi; th = ai % bi; r.lat = W + 1; end
      end
      4'h4: begin t = ai << s; r.cf = (s != 0) && (((ai >> (W - s)) & 1) == 1); end
      4'h5: begin t = ai >> s; r.cf = (s != 0) && (((ai >> (s - 1)) & 1) == 1); end
      4'h6: t = (ai << s) | (ai >> (W - s));
      4'h7: t = (ai >> s) | (ai << (W - s));
      4'h8: t = ai & bi;
      4'h9: t = ai | bi;
      4'hA: t = ai ^ bi;
      4'hB: t = ~(ai | bi);
      4'hC: t = ~(ai & bi);
      4'hD: t = ~(ai ^ bi);
      4'hE: t = (ai > bi) ? 1 : 0;
      default: t = (ai == bi) ? 1 : 0;
    endcase
    t = t & MASK;
    r.lo = t[W-1:0];
    r.hi = th[W-1:0];
    r.zf = (t == 0);
    r.sf = r.lo[W-1];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_applied = rst;
  end

  // Cycle-by-cycle comparison against the pending-result queue.
  res_t  ce;
  pend_t pp;
  bit    exp_ov, exp_ir;
  always @(negedge clk) begin
    exp_ov = (q.size() != 0) && (cyc >= q[0].due);
    exp_ir = !rst && ((q.size() == 0) || (exp_ov && bus.OUT_READY));
    chk("in_ready", bus.IN_READY, exp_ir);
    chk("out_valid", bus.OUT_VALID, exp_ov);
    if (exp_ov && bus.OUT_VALID) begin
      ce = q[0].r;
      chk("alu_out", bus.ALU_OUT, ce.lo);
      chk("alu_out_hi", bus.ALU_OUT_HI, ce.hi);
      chk("cf", bus.CF, ce.cf);
      chk("zf", bus.ZF, ce.zf);
      chk("sf", bus.SF, ce.sf);
      chk("dz", bus.DZ, ce.dz);
    end
    if (rst_applied)
      chk("reset_outputs", {bus.ALU_OUT, bus.ALU_OUT_HI, bus.CF, bus.ZF, bus.SF, bus.DZ}, 64'd0);
    if (rst) begin
      q.delete();
    end else begin
      if (exp_ov && bus.OUT_READY) void'(q.pop_front());
      if (bus.IN_VALID && bus.IN_READY) begin
        pp.r   = model(bus.SELC, bus.A, bus.B);
        pp.due = cyc + pp.r.lat;
        q.push_back(pp);
      end
    end
  end

  task automatic run_one(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic ecf, input logic ezf, input logic edz, input int elat);
    int n, lat;
    bit got;
    @(posedge clk); #1;
    bus.IN_VALID = 1'b1; bus.SELC = op; bus.A = a; bus.B = b;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.IN_READY && n < 30);
    chk({name, "_accept"}, bus.IN_READY, 1'b1);
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0; bus.A = W'($urandom); bus.B = W'($urandom); bus.SELC = 4'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 30) begin
      @(negedge clk); lat++;
      if (bus.OUT_VALID) got = 1'b1;
      else chk({name, "_busy_ready"}, bus.IN_READY, 1'b0);
    end
    chk({name, "_lat"}, lat, elat);
    chk({name, "_out"}, bus.ALU_OUT, elo);
    chk({name, "_hi"}, bus.ALU_OUT_HI, ehi);
    chk({name, "_cf"}, bus.CF, ecf);
    chk({name, "_zf"}, bus.ZF, ezf);
    chk({name, "_dz"}, bus.DZ, edz);
  endtask

  logic [W-1:0] sa[4] = '{8'hF0, 8'h01, 8'h7F, 8'h80};
  logic [W-1:0] sb[4] = '{8'h20, 8'hFF, 8'h01, 8'h80};
  logic [W-1:0] tmp;
  res_t mr;
  bit   taken;
  int   n, seen;

  initial begin
    rst = 1'b1;
    bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.SELC = '0; bus.OUT_READY = 1'b0;

    // Pin the model with hand-computed values.
    mr = model(4'h0, 8'hF0, 8'h20); chk("model_add", {mr.lo, mr.cf, mr.zf}, {8'h10, 1'b1, 1'b0});
    mr = model(4'h2, 8'h4C, 8'h1F); chk("model_mul", {mr.lo, mr.hi, mr.cf}, {8'h34, 8'h09, 1'b1});
    mr = model(4'h3, 8'h90, 8'h08); chk("model_div", {mr.lo, mr.hi, mr.dz}, {8'h12, 8'h00, 1'b0});
    mr = model(4'h3, 8'h55, 8'h00); chk("model_div0", {mr.lo, mr.hi, mr.dz, 8'(mr.lat)}, {8'hFF, 8'h55, 1'b1, 8'd1});
    mr = model(4'h4, 8'h85, 8'h09); chk("model_shl", {mr.lo, mr.cf}, {8'h0A, 1'b1});
    mr = model(4'h7, 8'hF0, 8'h04); chk("model_ror", {mr.lo, mr.cf}, {8'h0F, 1'b0});
    mr = model(4'hE, 8'hF0, 8'hF0); chk("model_gt", {mr.lo, mr.zf}, {8'h00, 1'b1});
    mr = model(4'hF, 8'hF0, 8'hF0); chk("model_eq", mr.lo, 8'h01);

    repeat (3) @(posedge clk);
    #1; rst = 1'b0; bus.OUT_READY = 1'b1;

    run_one("add",  4'h0, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    run_one("mul",  4'h2, 8'h4C, 8'h1F, 8'h34, 8'h09, 1'b1, 1'b0, 1'b0, 9);
    run_one("div",  4'h3, 8'h90, 8'h08, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 9);
    run_one("div0", 4'h3, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b1, 1);
    run_one("shl",  4'h4, 8'h85, 8'h09, 8'h0A, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    run_one("ror",  4'h7, 8'hF0, 8'h04, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run_one("eq",   4'hF, 8'hF0, 8'hF0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run_one("gt",   4'hE, 8'hF0, 8'hF0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1);

    // Back-to-back ADDs: one accept and one result per cycle.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.IN_VALID = 1'b1; bus.SELC = 4'h0; bus.A = sa[i]; bus.B = sb[i];
      @(negedge clk);
      chk("stream_ready", bus.IN_READY, 1'b1);
      if (i > 0) begin
        tmp = sa[i-1] + sb[i-1];
        chk("stream_valid", bus.OUT_VALID, 1'b1);
        chk("stream_out", bus.ALU_OUT, tmp);
      end
    end
    @(posedge clk); #1; bus.IN_VALID = 1'b0;
    @(negedge clk);
    tmp = sa[3] + sb[3];
    chk("stream_valid", bus.OUT_VALID, 1'b1);
    chk("stream_out", bus.ALU_OUT, tmp);

    // Back-pressure: result must hold while the consumer stalls.
    @(posedge clk); #1;
    bus.IN_VALID = 1'b1; bus.SELC = 4'hA; bus.A = 8'hC3; bus.B = 8'h5A; bus.OUT_READY = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0; bus.A = W'($urandom); bus.B = W'($urandom);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall_valid", bus.OUT_VALID, 1'b1);
      chk("stall_ready", bus.IN_READY, 1'b0);
      chk("stall_out", {bus.ALU_OUT, bus.SF, bus.ZF}, {8'h99, 1'b1, 1'b0});
    end
    @(posedge clk); #1; bus.OUT_READY = 1'b1;
    @(negedge clk);

    // Reset during the fourth BUSY cycle of a MUL aborts it.
    @(posedge clk); #1;
    bus.IN_VALID = 1'b1; bus.SELC = 4'h2; bus.A = 8'h4C; bus.B = 8'h1F;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.IN_READY && n < 30);
    @(posedge clk); #1; bus.IN_VALID = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk); chk("rst_in_ready", bus.IN_READY, 1'b0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.IN_READY, 1'b1);
    chk("outs_after_rst", {bus.OUT_VALID, bus.ALU_OUT, bus.ALU_OUT_HI, bus.CF, bus.ZF, bus.SF, bus.DZ}, 64'd0);
    seen = 0;
    repeat (12) begin @(negedge clk); if (bus.OUT_VALID) seen++; end
    chk("aborted_no_valid", seen, 0);

    // Randomized traffic with random back-pressure and occasional resets.
    taken = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 599) == 0);
      if (taken || !bus.IN_VALID) begin
        bus.IN_VALID = ($urandom_range(0, 9) < 7);
        bus.SELC = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) bus.SELC = 4'($urandom_range(2, 3));
        bus.A = W'($urandom);
        bus.B = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      end
      bus.OUT_READY = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      taken = bus.IN_VALID && bus.IN_READY;
    end

    @(posedge clk); #1;
    rst = 1'b0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
